// File: rtl/stream_demux_rr.sv
// stream_demux_rr: one-to-N stream demultiplexer with valid/ready handshakes.
// Each upstream word lands in a one-entry holding register of one downstream
// channel. The channel is picked round-robin by ptr, or steered directly
// through sel when sel_en is high.
//
// Handshake semantics (all ports): a word moves across an interface on a
// rising edge where valid and ready are both high. A producer holding valid
// keeps its data stable until the transfer happens. up_ready is combinational
// and depends on down_ready of the current target, so a full slot that is
// draining in the same cycle still accepts a new word with no bubble.
module stream_demux_rr #(
  parameter int N_OUT = 4,
  parameter int WIDTH = 8,
  localparam int SW = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  input  logic [WIDTH-1:0]       up_data,
  output logic                   up_ready,
  input  logic                   sel_en,
  input  logic [SW-1:0]          sel,
  output logic [N_OUT-1:0]       down_valid,
  output logic [N_OUT*WIDTH-1:0] down_data,
  input  logic [N_OUT-1:0]       down_ready,
  output logic [SW-1:0]          ptr
);

  // N_OUT widened by one bit so sel can be range-checked without truncation.
  localparam logic [SW:0] N_LIM  = (SW+1)'(N_OUT);
  localparam logic [SW-1:0] PTR_LAST = SW'(N_OUT - 1);

  logic [N_OUT-1:0] slot_valid;
  logic [WIDTH-1:0] slot_data [N_OUT];

  logic             legal;
  logic [SW-1:0]    tgt;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] drain;
  logic [N_OUT-1:0] load;
  logic             accept;

  // Target selection, legality and the accept/drain strobes for this cycle.
  always_comb begin
    legal = !sel_en || ({1'b0, sel} < N_LIM);
    tgt   = sel_en ? sel : ptr;
    hit   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      hit[i] = legal && (tgt == SW'(i));
    end
    drain    = slot_valid & down_ready;
    // An illegal target leaves hit all-zero, which forces up_ready low.
    up_ready = |(hit & (~slot_valid | down_ready));
    accept   = up_valid && up_ready;
    load     = accept ? hit : '0;
  end

  // Per-channel holding registers: a load wins over a drain on the same slot,
  // so a simultaneous accept and drain replaces the word and stays valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_OUT; i++) begin
      if (rst) begin
        slot_valid[i] <= 1'b0;
        slot_data[i]  <= '0;
      end else if (load[i]) begin
        slot_valid[i] <= 1'b1;
        slot_data[i]  <= up_data;
      end else if (drain[i]) begin
        slot_valid[i] <= 1'b0;
      end
    end
  end

  // Round-robin pointer: moves only on accepts made in round-robin mode and
  // never skips a busy channel; wraps explicitly for non-power-of-two N_OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && !sel_en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + SW'(1);
    end
  end

  // Flatten the holding registers onto the packed downstream bus.
  always_comb begin
    down_valid = slot_valid;
    down_data  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      down_data[i*WIDTH +: WIDTH] = slot_data[i];
    end
  end

endmodule
